// File: rtl/pwm_fade_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pwm_fade_sequencer
// Description : Ramps the PWM duty toward a requested target. Each move is one
//               programmable step, taken every (interval+1) enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_fade_sequencer #(
    parameter int DUTY_W = 8,
    parameter int INTV_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DUTY_W-1:0] cfg_target,
    input  logic [DUTY_W-1:0] cfg_step,
    input  logic [INTV_W-1:0] cfg_interval,
    input  logic              enable,
    input  logic              abort,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RAMP   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t            r_state,    w_state_nxt;
    logic [DUTY_W-1:0] r_duty,     w_duty_nxt;
    logic [DUTY_W-1:0] r_target,   w_target_nxt;
    logic [DUTY_W-1:0] r_step,     w_step_nxt;
    logic [INTV_W-1:0] r_interval, w_interval_nxt;
    logic [INTV_W-1:0] r_timer,    w_timer_nxt;
    logic              r_busy,     w_busy_nxt;
    logic              r_done,     w_done_nxt;

    logic              w_up;
    logic [DUTY_W:0]   w_gap;
    logic [DUTY_W-1:0] w_duty_step;

    // Gap is computed one bit wider so a step larger than the remaining
    // distance clamps to the target instead of wrapping.
    assign w_up        = (r_target > r_duty);
    assign w_gap       = w_up ? ({1'b0, r_target} - {1'b0, r_duty})
                              : ({1'b0, r_duty} - {1'b0, r_target});
    assign w_duty_step = (w_gap <= {1'b0, r_step}) ? r_target
                       : (w_up ? (r_duty + r_step) : (r_duty - r_step));

    always_comb begin
        w_state_nxt    = r_state;
        w_duty_nxt     = r_duty;
        w_target_nxt   = r_target;
        w_step_nxt     = r_step;
        w_interval_nxt = r_interval;
        w_timer_nxt    = r_timer;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_valid) begin
                    w_target_nxt   = cfg_target;
                    w_step_nxt     = (cfg_step == '0) ? DUTY_W'(1) : cfg_step;
                    w_interval_nxt = cfg_interval;
                    w_timer_nxt    = '0;
                    if (cfg_target == r_duty) begin
                        w_state_nxt = S_FINISH;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_RAMP;
                        w_busy_nxt  = 1'b1;
                    end
                end
            end
            S_RAMP: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else if (enable) begin
                    if (r_timer == r_interval) begin
                        w_timer_nxt = '0;
                        w_duty_nxt  = w_duty_step;
                        if (w_duty_step == r_target) begin
                            w_state_nxt = S_FINISH;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_timer_nxt = r_timer + INTV_W'(1);
                    end
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_duty     <= '0;
            r_target   <= '0;
            r_step     <= '0;
            r_interval <= '0;
            r_timer    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_duty     <= w_duty_nxt;
            r_target   <= w_target_nxt;
            r_step     <= w_step_nxt;
            r_interval <= w_interval_nxt;
            r_timer    <= w_timer_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign cfg_ready = (r_state == S_IDLE);
    assign duty_out  = r_duty;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire
